// File: rtl/cbfp_block_scaler.sv
// Convergent block-floating-point scaler: ping-pong buffers one block, then re-emits it shifted by the block exponent.
// Optional macro CBFP_ROUND_EN selects round-half-up with saturation instead of floor truncation.
//
// state   | meaning
// S_IDLE  | no completed bank waiting
// S_CALC  | derive block shift from the latched max index
// S_DRAIN | emit one buffered sample per cycle
module cbfp_block_scaler #(
  parameter  int WIDTH     = 25,
  parameter  int OUT_WIDTH = 13,
  parameter  int BLOCK_LEN = 64,
  localparam int IDXW      = $clog2(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        din_valid,
  input  logic signed [WIDTH-1:0]     din_re,
  input  logic signed [WIDTH-1:0]     din_im,
  input  logic [IDXW-1:0]             idx_re,
  input  logic [IDXW-1:0]             idx_im,
  output logic                        dout_valid,
  output logic signed [OUT_WIDTH-1:0] dout_re,
  output logic signed [OUT_WIDTH-1:0] dout_im,
  output logic                        dout_first,
  output logic                        dout_last,
  output logic [IDXW-1:0]             blk_exp
);

  localparam int              CNTW = $clog2(BLOCK_LEN);
  localparam logic [CNTW-1:0] LAST = CNTW'(BLOCK_LEN - 1);

`ifdef CBFP_ROUND_EN
  localparam logic signed [WIDTH:0] SAT_MAX = (WIDTH+1)'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [WIDTH:0] SAT_MIN = (WIDTH+1)'(-(2 ** (OUT_WIDTH - 1)));
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DRAIN} state_t;

  logic [2*WIDTH-1:0] r_mem [2*BLOCK_LEN];
  logic [CNTW-1:0]    r_wr_cnt;
  logic [CNTW-1:0]    r_rd_cnt;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic               r_pend;
  logic [IDXW-1:0]    r_m_run;
  logic [IDXW-1:0]    r_m_blk;
  logic [IDXW-1:0]    r_blk_exp;
  state_t             r_state;
  state_t             w_next;
  logic               w_take;
  logic               w_load_exp;
  logic               w_wr_last;
  logic [IDXW-1:0]    w_idx_max;
  logic [IDXW-1:0]    w_m_new;
  logic [IDXW:0]      w_m_plus2;
  logic [IDXW-1:0]    w_shift;
  logic [2*WIDTH-1:0] w_rd;

  function automatic logic signed [OUT_WIDTH-1:0] scale(input logic signed [WIDTH-1:0] x,
                                                        input logic [IDXW-1:0] s);
`ifdef CBFP_ROUND_EN
    logic signed [WIDTH:0] e;
    e = {x[WIDTH-1], x};
    if (s != '0) e = e + ((WIDTH+1)'(1) << (s - IDXW'(1)));
    e = e >>> s;
    if (e > SAT_MAX) return OUT_WIDTH'(SAT_MAX);
    if (e < SAT_MIN) return OUT_WIDTH'(SAT_MIN);
    return OUT_WIDTH'(e);
`else
    return OUT_WIDTH'(x >>> s);
`endif
  endfunction

  assign w_idx_max = (idx_re > idx_im) ? idx_re : idx_im;
  assign w_m_new   = (w_idx_max > r_m_run) ? w_idx_max : r_m_run;
  assign w_wr_last = din_valid && (r_wr_cnt == LAST);

  always_ff @(posedge clk) begin
    if (din_valid) r_mem[{r_wr_bank, r_wr_cnt}] <= {din_re, din_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_m_run   <= '0;
      r_m_blk   <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_pend <= w_wr_last | (r_pend & ~w_take);
      if (din_valid) begin
        r_wr_cnt <= r_wr_cnt + CNTW'(1);
        if (w_wr_last) begin
          r_m_blk   <= w_m_new;
          r_m_run   <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_m_run <= w_m_new;
        end
      end
    end
  end

  // A value with index m needs m+2 signed bits; shift off whatever exceeds OUT_WIDTH.
  assign w_m_plus2 = {1'b0, r_m_blk} + (IDXW+1)'(2);
  assign w_shift   = (w_m_plus2 > (IDXW+1)'(OUT_WIDTH)) ?
                     IDXW'(w_m_plus2 - (IDXW+1)'(OUT_WIDTH)) : '0;

  // Back-to-back banks skip S_CALC: the shift is loaded on the last drain cycle
  // so a gap-free input stream stays gap-free at the output.
  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    w_load_exp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_next = S_CALC;
          w_take = 1'b1;
        end
      end
      S_CALC: begin
        w_next     = S_DRAIN;
        w_load_exp = 1'b1;
      end
      S_DRAIN: begin
        if (r_rd_cnt == LAST) begin
          if (r_pend) begin
            w_take     = 1'b1;
            w_load_exp = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_blk_exp <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_exp) r_blk_exp <= w_shift;
      if (r_state == S_DRAIN) begin
        r_rd_cnt <= r_rd_cnt + CNTW'(1);
        if (r_rd_cnt == LAST) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  assign w_rd       = r_mem[{r_rd_bank, r_rd_cnt}];
  assign dout_valid = (r_state == S_DRAIN);
  assign dout_re    = dout_valid ? scale(w_rd[2*WIDTH-1:WIDTH], r_blk_exp) : '0;
  assign dout_im    = dout_valid ? scale(w_rd[WIDTH-1:0], r_blk_exp) : '0;
  assign dout_first = dout_valid && (r_rd_cnt == '0);
  assign dout_last  = dout_valid && (r_rd_cnt == LAST);
  assign blk_exp    = r_blk_exp;

endmodule

// File: tb/tb_cbfp_block_scaler.sv
// Bench for cbfp_block_scaler (BLOCK_LEN=8): random blocks against an arithmetic reference model.
// Expected values follow CBFP_ROUND_EN when the macro is defined.
module tb_cbfp_block_scaler;
  localparam int WIDTH = 25;
  localparam int OUT_WIDTH = 13;
  localparam int BLOCK_LEN = 8;
  localparam int IDXW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic [WIDTH-1:0] din_re = '0;
  logic [WIDTH-1:0] din_im = '0;
  logic [IDXW-1:0] idx_re = '0;
  logic [IDXW-1:0] idx_im = '0;
  logic dout_valid;
  logic signed [OUT_WIDTH-1:0] dout_re;
  logic signed [OUT_WIDTH-1:0] dout_im;
  logic dout_first;
  logic dout_last;
  logic [IDXW-1:0] blk_exp;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int q_re[$], q_im[$], q_exp[$], q_cyc[$];
  bit q_first[$], q_last[$];
  int e_re[$], e_im[$], e_exp[$], e_acc[$];

  cbfp_block_scaler #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .BLOCK_LEN(BLOCK_LEN)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .idx_re(idx_re), .idx_im(idx_im), .dout_valid(dout_valid), .dout_re(dout_re),
    .dout_im(dout_im), .dout_first(dout_first), .dout_last(dout_last), .blk_exp(blk_exp));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      q_re.push_back(int'(dout_re));
      q_im.push_back(int'(dout_im));
      q_exp.push_back(int'(blk_exp));
      q_first.push_back(dout_first);
      q_last.push_back(dout_last);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // smallest i such that v fits in i+2 signed bits
  function automatic int idx_of(int v);
    for (int i = 0; i < 24; i++)
      if (v >= -(1 << (i + 1)) && v < (1 << (i + 1))) return i;
    return 23;
  endfunction

  function automatic int ref_scale(int v, int s);
    int p, q;
    if (s == 0) return v;
    p = 1 << s;
`ifdef CBFP_ROUND_EN
    v = v + p / 2;
`endif
    q = v / p;
    if (v < 0 && q * p != v) q = q - 1;
`ifdef CBFP_ROUND_EN
    if (q > (1 << (OUT_WIDTH - 1)) - 1) q = (1 << (OUT_WIDTH - 1)) - 1;
    if (q < -(1 << (OUT_WIDTH - 1))) q = -(1 << (OUT_WIDTH - 1));
`endif
    return q;
  endfunction

  function automatic int rand_val(int bits);
    return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_re.delete(); q_im.delete(); q_exp.delete(); q_cyc.delete();
    q_first.delete(); q_last.delete();
    e_re.delete(); e_im.delete(); e_exp.delete(); e_acc.delete();
  endtask

  task automatic drive(input int re, input int im);
    din_valid = 1'b1;
    din_re = WIDTH'(re);
    din_im = WIDTH'(im);
    idx_re = IDXW'(idx_of(re));
    idx_im = IDXW'(idx_of(im));
    step();
    din_valid = 1'b0;
  endtask

  task automatic send_block(input int re[BLOCK_LEN], input int im[BLOCK_LEN], input bit gaps);
    int m, s;
    m = 0;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      if (idx_of(re[i]) > m) m = idx_of(re[i]);
      if (idx_of(im[i]) > m) m = idx_of(im[i]);
    end
    s = (m + 2 > OUT_WIDTH) ? m + 2 - OUT_WIDTH : 0;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      e_re.push_back(ref_scale(re[i], s));
      e_im.push_back(ref_scale(im[i], s));
      e_exp.push_back(s);
    end
    for (int i = 0; i < BLOCK_LEN; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      drive(re[i], im[i]);
    end
    e_acc.push_back(cyc);
  endtask

  task automatic rand_block(input int bits, output int re[BLOCK_LEN], output int im[BLOCK_LEN]);
    for (int i = 0; i < BLOCK_LEN; i++) begin
      re[i] = rand_val(bits);
      im[i] = rand_val(bits);
    end
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 400 && q_re.size() < n; k++) step();
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_chk++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", dout_valid); else n_pass++;
    n_chk++; if (dout_re !== 0 || dout_im !== 0) $display("FAIL reset_data: got %0d/%0d want 0/0", dout_re, dout_im); else n_pass++;
    n_chk++; if (blk_exp !== 0) $display("FAIL reset_exp: got %0d want 0", blk_exp); else n_pass++;
    n_chk++; if (dout_first !== 1'b0 || dout_last !== 1'b0) $display("FAIL reset_flags: got %0b%0b want 00", dout_first, dout_last); else n_pass++;
    @(negedge clk) rst = 1'b0;
    repeat (5) step();
    n_chk++; if (dout_valid !== 1'b0) $display("FAIL idle_valid: got %0b want 0", dout_valid); else n_pass++;
  endtask

  task automatic test_zero_block();
    int re[BLOCK_LEN], im[BLOCK_LEN];
    clear_q();
    for (int i = 0; i < BLOCK_LEN; i++) begin re[i] = 0; im[i] = 0; end
    send_block(re, im, 1'b0);
    wait_out(BLOCK_LEN);
    n_chk++; if (q_re.size() !== BLOCK_LEN) $display("FAIL zero_count: got %0d want %0d", q_re.size(), BLOCK_LEN); else n_pass++;
    if (q_re.size() > 0) begin
      n_chk++; if (q_cyc[0] !== e_acc[0] + 2) $display("FAIL zero_latency: got cycle %0d want %0d", q_cyc[0], e_acc[0] + 2); else n_pass++;
      n_chk++; if (q_exp[0] !== 0) $display("FAIL zero_exp: got %0d want 0", q_exp[0]); else n_pass++;
    end
    for (int i = 0; i < q_re.size() && i < BLOCK_LEN; i++) begin
      n_chk++;
      if (q_re[i] !== 0 || q_im[i] !== 0 || q_first[i] !== (i == 0) || q_last[i] !== (i == BLOCK_LEN - 1))
        $display("FAIL zero_sample[%0d]: got %0d/%0d f=%0b l=%0b want 0/0 f=%0b l=%0b",
                 i, q_re[i], q_im[i], q_first[i], q_last[i], i == 0, i == BLOCK_LEN - 1);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int re[BLOCK_LEN], im[BLOCK_LEN];
    int n;
    clear_q();
    n = 4 * BLOCK_LEN;
    for (int i = 0; i < BLOCK_LEN; i++) begin re[i] = 3072; im[i] = rand_val(10); end
    re[3] = 8388607;
    send_block(re, im, 1'b0);
    rand_block(10, re, im);
    re[0] = 1000; re[5] = -513;
    send_block(re, im, 1'b0);
    rand_block(20, re, im);
    im[2] = -8388608;
    send_block(re, im, 1'b0);
    rand_block(17, re, im);
    re[7] = 100000;
    send_block(re, im, 1'b0);
    wait_out(n);
    n_chk++; if (q_re.size() !== n) $display("FAIL b2b_count: got %0d want %0d", q_re.size(), n); else n_pass++;
    if (q_re.size() == n) begin
      n_chk++; if (q_cyc[0] !== e_acc[0] + 2) $display("FAIL b2b_latency: got cycle %0d want %0d", q_cyc[0], e_acc[0] + 2); else n_pass++;
      n_chk++; if (q_cyc[n-1] !== q_cyc[0] + n - 1) $display("FAIL b2b_contiguous: got span %0d want %0d", q_cyc[n-1] - q_cyc[0], n - 1); else n_pass++;
      n_chk++;
      if (q_exp[0] !== 11 || q_exp[8] !== 0 || q_exp[16] !== 11 || q_exp[24] !== 5)
        $display("FAIL b2b_exps: got %0d,%0d,%0d,%0d want 11,0,11,5", q_exp[0], q_exp[8], q_exp[16], q_exp[24]);
      else n_pass++;
`ifdef CBFP_ROUND_EN
      n_chk++; if (q_re[3] !== 4095 || q_re[0] !== 2) $display("FAIL b2b_posmax: got %0d,%0d want 4095,2", q_re[3], q_re[0]); else n_pass++;
`else
      n_chk++; if (q_re[3] !== 4095 || q_re[0] !== 1) $display("FAIL b2b_posmax: got %0d,%0d want 4095,1", q_re[3], q_re[0]); else n_pass++;
`endif
      n_chk++; if (q_re[8] !== 1000 || q_re[13] !== -513) $display("FAIL b2b_exact: got %0d,%0d want 1000,-513", q_re[8], q_re[13]); else n_pass++;
      n_chk++; if (q_im[18] !== -4096) $display("FAIL b2b_negmax: got %0d want -4096", q_im[18]); else n_pass++;
    end
    for (int i = 0; i < q_re.size() && i < n; i++) begin
      n_chk++;
      if (q_re[i] !== e_re[i] || q_im[i] !== e_im[i] || q_exp[i] !== e_exp[i] ||
          q_first[i] !== (i % BLOCK_LEN == 0) || q_last[i] !== (i % BLOCK_LEN == BLOCK_LEN - 1))
        $display("FAIL b2b_sample[%0d]: got %0d/%0d exp=%0d f=%0b l=%0b want %0d/%0d exp=%0d",
                 i, q_re[i], q_im[i], q_exp[i], q_first[i], q_last[i], e_re[i], e_im[i], e_exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random_gaps();
    int re[BLOCK_LEN], im[BLOCK_LEN];
    int n;
    clear_q();
    n = 5 * BLOCK_LEN;
    for (int b = 0; b < 5; b++) begin
      rand_block(int'($urandom_range(2, WIDTH)), re, im);
      send_block(re, im, 1'b1);
    end
    wait_out(n);
    n_chk++; if (q_re.size() !== n) $display("FAIL rand_count: got %0d want %0d", q_re.size(), n); else n_pass++;
    for (int i = 0; i < q_re.size() && i < n; i++) begin
      n_chk++;
      if (q_re[i] !== e_re[i] || q_im[i] !== e_im[i] || q_exp[i] !== e_exp[i] ||
          q_first[i] !== (i % BLOCK_LEN == 0) || q_last[i] !== (i % BLOCK_LEN == BLOCK_LEN - 1))
        $display("FAIL rand_sample[%0d]: got %0d/%0d exp=%0d f=%0b l=%0b want %0d/%0d exp=%0d",
                 i, q_re[i], q_im[i], q_exp[i], q_first[i], q_last[i], e_re[i], e_im[i], e_exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_drain();
    int re[BLOCK_LEN], im[BLOCK_LEN];
    int want4;
    clear_q();
    rand_block(20, re, im);
    send_block(re, im, 1'b0);
    for (int i = 0; i < 3; i++) drive(rand_val(24), rand_val(24));
    repeat (2) step();
    want4 = e_re[3];
    n_chk++; if (dout_valid !== 1'b1 || int'(dout_re) !== want4) $display("FAIL mid_4th: got v=%0b re=%0d want v=1 re=%0d", dout_valid, dout_re, want4); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (dout_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b want 0", dout_valid); else n_pass++;
    n_chk++; if (dout_re !== 0 || dout_im !== 0 || blk_exp !== 0) $display("FAIL mid_rst_data: got %0d/%0d exp=%0d want 0/0 exp=0", dout_re, dout_im, blk_exp); else n_pass++;
    n_chk++; if (dout_first !== 1'b0 || dout_last !== 1'b0) $display("FAIL mid_rst_flags: got %0b%0b want 00", dout_first, dout_last); else n_pass++;
    step();
    @(negedge clk) rst = 1'b0;
    clear_q();
    rand_block(22, re, im);
    send_block(re, im, 1'b0);
    wait_out(BLOCK_LEN);
    n_chk++; if (q_re.size() !== BLOCK_LEN) $display("FAIL post_count: got %0d want %0d", q_re.size(), BLOCK_LEN); else n_pass++;
    if (q_re.size() > 0) begin
      n_chk++; if (q_cyc[0] !== e_acc[0] + 2) $display("FAIL post_latency: got cycle %0d want %0d", q_cyc[0], e_acc[0] + 2); else n_pass++;
    end
    for (int i = 0; i < q_re.size() && i < BLOCK_LEN; i++) begin
      n_chk++;
      if (q_re[i] !== e_re[i] || q_im[i] !== e_im[i] || q_exp[i] !== e_exp[i] ||
          q_first[i] !== (i == 0) || q_last[i] !== (i == BLOCK_LEN - 1))
        $display("FAIL post_sample[%0d]: got %0d/%0d exp=%0d f=%0b l=%0b want %0d/%0d exp=%0d",
                 i, q_re[i], q_im[i], q_exp[i], q_first[i], q_last[i], e_re[i], e_im[i], e_exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_back_to_back();
    test_random_gaps();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
